// File: rtl/fetch_queue.sv
// fetch_queue
// -----------
// Instruction fetch front end with a small show-ahead queue between the
// instruction SRAM and the decode stage.
//
// A free-running fetch PC issues one sequential request per cycle whenever
// there is guaranteed room for the response. The SRAM returns data one cycle
// after the request, and that response is written at the queue tail together
// with its PC. Decode sees the head entry combinationally on deq_*.
//
// Handshake (deq side): an entry moves from the queue to ID on every rising
// edge where deq_valid && deq_ready are both high (deq_fire). deq_valid never
// depends on deq_ready. deq_pc/deq_instr are stable while deq_valid is high
// and deq_ready is low. The imem side has no back-pressure: imem_req is a
// one-cycle command and its data is captured unconditionally one cycle later.
//
// Ports
//   clk          in   1     rising-edge clock
//   rst          in   1     synchronous active-high reset
//   imem_addr    out  XLEN  fetch address (word address = imem_addr[15:2])
//   imem_req     out  1     fetch issued this cycle
//   imem_rdata   in   32    instruction word, valid the cycle after imem_req
//   redirect     in   1     taken branch/jump from EXE (flushes the queue)
//   redirect_pc  in   XLEN  redirect target (low two bits ignored)
//   deq_valid    out  1     head entry available to ID
//   deq_ready    in   1     ID accepts the head entry
//   deq_pc       out  XLEN  PC of the head entry
//   deq_instr    out  32    instruction of the head entry
//   count        out  CW    number of occupied entries

module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [XLEN-1:0]            imem_addr,
  output logic                       imem_req,
  input  logic [31:0]                imem_rdata,
  input  logic                       redirect,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [XLEN-1:0]            deq_pc,
  output logic [31:0]                deq_instr,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  // DEPTH expressed in the widths used by the credit compare and the
  // full-queue check.
  localparam logic [CW:0]   DEPTH_CREDIT = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_FULL   = CW'(DEPTH);

  // Fetch state
  logic [XLEN-1:0] fetch_pc;
  logic            inflight;     // request issued last cycle, not killed
  logic [XLEN-1:0] inflight_pc;  // PC of that request

  // Queue state
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count_q;
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [31:0]     instr_mem [DEPTH];

  // Per-cycle events
  logic            deq_fire;
  logic            enq;
  logic [CW:0]     credit_used;

  // The two low bits of the redirect target are forced to zero, so they are
  // intentionally not consumed.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // ---------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------

  assign deq_valid = !rst && !redirect && (count_q != '0);
  assign deq_fire  = deq_valid && deq_ready;

  // A response is written only if its request survived; redirect or reset
  // in the response cycle kills it.
  assign enq = inflight && !redirect && !rst;

  // Slots already spoken for after this edge: current entries plus the
  // response arriving now, minus the entry leaving now. A new request is
  // allowed only if that leaves at least one free slot for its own response,
  // which is what makes an enqueue into a full queue impossible. deq_fire
  // implies count_q >= 1, so the subtraction cannot underflow.
  assign credit_used = {1'b0, count_q}
                     + {{CW{1'b0}}, inflight}
                     - {{CW{1'b0}}, deq_fire};

  assign imem_req  = !rst && !redirect && (credit_used < DEPTH_CREDIT);
  assign imem_addr = fetch_pc;

  // Show-ahead head entry.
  assign deq_pc    = pc_mem[head];
  assign deq_instr = instr_mem[head];
  assign count     = count_q;

  // ---------------------------------------------------------------------
  // Fetch PC and in-flight tracking
  // ---------------------------------------------------------------------

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
    end else if (redirect) begin
      fetch_pc    <= {redirect_pc[XLEN-1:2], 2'b00};
      inflight    <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + XLEN'(4);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Queue pointers and occupancy
  // ---------------------------------------------------------------------

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst || redirect) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (enq) begin
        tail <= tail + PW'(1);
      end
      if (deq_fire) begin
        head <= head + PW'(1);
      end
      case ({enq, deq_fire})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset; occupancy alone says which entries are live.
  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem[tail]    <= inflight_pc;
      instr_mem[tail] <= imem_rdata;
    end
  end

  // ---------------------------------------------------------------------
  // Structural invariants
  // ---------------------------------------------------------------------

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(enq && !deq_fire && (count_q == DEPTH_FULL)))
        else $error("enqueue into a full queue");
      assert (count_q <= DEPTH_FULL)
        else $error("occupancy above DEPTH");
    end
  end

endmodule
